nand_init_sequencer: RTL

NAND_INIT_SEQUENCER -- requirements
Module: nand_init_sequencer

---
 rtl/nand_pkg.sv | 30 +++
 rtl/nand_init_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/nand_pkg.sv
// Shared nand_master command codes and init-sequencer state encoding.
package nand_pkg;

  localparam logic [5:0] MReset             = 6'h01;
  localparam logic [5:0] MNandReset         = 6'h04;
  localparam logic [5:0] MNandReadId        = 6'h06;
  localparam logic [5:0] MiGetStatus        = 6'h0D;
  localparam logic [5:0] MiChipEnable       = 6'h0E;
  localparam logic [5:0] MiGetParamPageByte = 6'h12;
  localparam logic [5:0] MiGetIdByte        = 6'h13;
  localparam logic [5:0] MiSetDataPageByte  = 6'h15;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StIssue   = 3'd1;
  localparam state_t StSettle  = 3'd2;
  localparam state_t StWait    = 3'd3;
  localparam state_t StCapture = 3'd4;
  localparam state_t StFail    = 3'd5;

  localparam logic [3:0] FirstIdStep = 4'd4;
  localparam logic [3:0] StatusStep  = 4'd9;

  typedef struct packed {
    logic [5:0] cmd;
    logic [7:0] arg;
  } step_entry_t;

endpackage

// File: rtl/nand_init_sequencer.sv
// Drives nand_master through reset, chip enable, READ ID and status read, capturing
// the five ID bytes and the status byte, with a per-step busy timeout.
module nand_init_sequencer
  import nand_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535,
  parameter logic [7:0]  CE_SEL         = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        seq_busy,
  output logic        done,
  output logic        error,
  output logic [39:0] id_out,
  output logic [7:0]  status_out,
  output logic [5:0]  nm_cmd,
  output logic [7:0]  nm_data_in,
  output logic        nm_activate,
  input  logic        nm_busy,
  input  logic [7:0]  nm_data_out
);

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [7:0]  arg_q, arg_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [39:0] id_q, id_d;
  logic [7:0]  status_q, status_d;
  step_entry_t next_entry;

  function automatic step_entry_t step_entry(input logic [3:0] step);
    step_entry_t e;
    e.cmd = MiGetIdByte;
    e.arg = 8'h00;
    case (step)
      4'd0: e.cmd = MReset;
      4'd1: begin
        e.cmd = MiChipEnable;
        e.arg = CE_SEL;
      end
      4'd2: e.cmd = MNandReset;
      4'd3: e.cmd = MNandReadId;
      4'd9: e.cmd = MiGetStatus;
      default: ;
    endcase
    return e;
  endfunction

  assign next_entry = step_entry(step_d);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    arg_d    = arg_q;
    done_d   = 1'b0;
    error_d  = error_q;
    id_d     = id_q;
    status_d = status_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          error_d = 1'b0;
          step_d  = 4'd0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 16'd0;
        state_d = StSettle;
      end
      StSettle: state_d = StWait;
      StWait: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (!nm_busy) begin
          state_d = StCapture;
        end else if (cnt_d >= TIMEOUT_CYCLES) begin
          state_d = StFail;
        end
      end
      StCapture: begin
        for (int b = 0; b < 5; b++) begin
          if (step_q == FirstIdStep + 4'(b)) id_d[8*b +: 8] = nm_data_out;
        end
        if (step_q == StatusStep) begin
          status_d = nm_data_out;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          step_d  = step_q + 4'd1;
          state_d = StIssue;
        end
      end
      StFail: begin
        error_d = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Latch the command on entry to ISSUE so it holds steady until WAIT exits.
    if (state_d == StIssue) begin
      cmd_d = next_entry.cmd;
      arg_d = next_entry.arg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      step_q   <= 4'd0;
      cnt_q    <= 16'd0;
      cmd_q    <= 6'd0;
      arg_q    <= 8'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      id_q     <= 40'd0;
      status_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      arg_q    <= arg_d;
      done_q   <= done_d;
      error_q  <= error_d;
      id_q     <= id_d;
      status_q <= status_d;
    end
  end

  assign nm_activate = (state_q == StIssue);
  assign seq_busy    = (state_q != StIdle);
  assign nm_cmd      = cmd_q;
  assign nm_data_in  = arg_q;
  assign done        = done_q;
  assign error       = error_q;
  assign id_out      = id_q;
  assign status_out  = status_q;

endmodule
